micro_sequencer: RTL and testbench
==================================

Name: micro_sequencer

Overview:
Micro-program counter and next-address logic that drives the addr input of the control ROM and consumes the 16-bit control word it returns. Each cycle it decodes the sequencing field of the current word and selects the next micro-address: increment, jump, conditional branch, call/return through a small return stack, opcode dispatch, or halt. It sits directly upstream of the control ROM. It also consumes that ROM's output in a closed loop, with the ROM combinational in between.

Parameters:
ADDR_W, 8, micro-address width; must match the control ROM address width.
STACK_DEPTH, 4, return-stack entries, 1..8.
START_ADDR, 0, micro-address loaded on start.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  begin execution at START_ADDR; honoured only in IDLE or HALT
stall  in  1  hold the current micro-address and all state
opcode  in  4  macro-instruction opcode, used by DISPATCH
cond  in  8  condition flags from the datapath
word  in  16  control word from the ROM for the current addr (combinational)
addr  out  ADDR_W  current micro-address to the ROM; driven directly from the uPC register
running  out  1  high in RUN
halted  out  1  high in HALT
err  out  1  sticky error: stack overflow or underflow

Behaviour:
Word fields:
- [15:13] seq op: 000 NEXT, 001 JUMP, 010 BR_T, 011 BR_F, 100 CALL, 101 RET, 110 DISPATCH, 111 HALT
- [12:10] condition-select index into cond
- [ADDR_W-1:0] target
- Other bits are ignored by this block.

Reset (rst_n low at a clock edge):
- state=IDLE, uPC=0, stack pointer=0, err=0, running=0, halted=0.
- Stack contents are don't-care.
- Reset overrides start and stall, including mid-program.

States:
- IDLE: addr=uPC; word is ignored. start → RUN with uPC=START_ADDR on the next edge.
- RUN: if stall=1, nothing changes. Otherwise the next uPC is set by seq op:
  - NEXT: uPC+1, wrapping at 2^ADDR_W (0xFF→0x00).
  - JUMP: target.
  - BR_T: target if cond[sel]=1, else uPC+1.
  - BR_F: target if cond[sel]=0, else uPC+1.
  - CALL: push uPC+1 (wrapped), uPC=target. If the stack is full: no push, err←1, go to HALT.
  - RET: pop into uPC. If the stack is empty: err←1, go to HALT.
  - DISPATCH: uPC = target + zero-extended opcode, modulo 2^ADDR_W.
  - HALT: go to HALT. uPC holds the address of the HALT word.
- HALT: uPC holds. start → RUN with uPC=START_ADDR, stack pointer cleared, err cleared. stall is ignored.

Timing and outputs:
- Latency: one cycle per micro-instruction. A new addr appears the cycle after the decision edge.
- running and halted are registered and derived from state.
- err is sticky until reset or a start out of HALT.
- start while in RUN is ignored.
- stall and start together in IDLE/HALT: start wins, because stall only affects RUN.
- There are no X-propagating paths; all next-state logic fully assigns every register.

Test Plan:
- Reset, start=1 for one cycle, ROM words 0x0000 at 0..2 and 0xE000 at 3 → addr sequence 0,1,2,3 then halted=1 with addr=3; running drops the same cycle halted rises.
- JUMP word 0x2050 at addr 0x10 → next addr 0x50. At 0xFF, NEXT → addr 0x00 (wrap).
- BR_T with sel=2 (word 0x4830): cond=0x04 → addr 0x30; cond=0x00 → addr+1. BR_F mirrors this with opposite results.
- CALL 0x8040 at 0x05 → addr 0x40; RET (0xA000) at 0x40 → addr 0x06. Five nested CALLs with STACK_DEPTH=4 → err=1, halted=1 after the fifth; RET with an empty stack → err=1.
- DISPATCH 0xC0F8 with opcode=0xA → addr 0x02 (wrap). Holding stall=1 for 3 cycles in RUN → addr and stack unchanged, and the sequence resumes exactly afterwards.
- Drive rst_n=0 mid-RUN with a non-empty stack → next edge gives addr=0, IDLE, err=0. start from HALT after an error → err clears and addr=START_ADDR.

Source files
------------

// File: rtl/micro_sequencer.sv
// micro_sequencer: micro-PC and next-address logic for the control ROM.
// Decodes the sequencing field of the current control word each cycle.
module micro_sequencer #(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4,
    parameter int START_ADDR  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stall,
    input  logic [3:0]        opcode,
    input  logic [7:0]        cond,
    input  logic [15:0]       word,
    output logic [ADDR_W-1:0] addr,
    output logic              running,
    output logic              halted,
    output logic              err
);

    localparam int SP_W = $clog2(STACK_DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HALT
    } state_t;

    typedef enum logic [2:0] {
        OP_NEXT,
        OP_JUMP,
        OP_BR_T,
        OP_BR_F,
        OP_CALL,
        OP_RET,
        OP_DISP,
        OP_HALT
    } seq_t;

    state_t            state;
    logic [ADDR_W-1:0] upc;
    logic [SP_W-1:0]   sp;
    logic [ADDR_W-1:0] stack [STACK_DEPTH];

    seq_t              op;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] upc_inc;
    logic [ADDR_W-1:0] top;
    logic              taken;
    logic              full;
    logic              empty;
    logic              push;

    assign addr    = upc;
    assign op      = seq_t'(word[15:13]);
    assign target  = word[ADDR_W-1:0];
    assign upc_inc = upc + ADDR_W'(1);
    assign taken   = cond[word[12:10]];
    assign full    = (sp == SP_W'(STACK_DEPTH));
    assign empty   = (sp == '0);
    assign push    = (state == S_RUN) && !stall
                     && (op == OP_CALL) && !full;

    // Top-of-stack read: entry just below the stack pointer
    always_comb begin
        top = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (int'(sp) == i + 1) top = stack[i];
        end
    end

    // Return-stack storage; contents need no reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (push && int'(sp) == i) stack[i] <= upc_inc;
        end
    end

    // Sequencer FSM: state, uPC, stack pointer, status flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            upc     <= '0;
            sp      <= '0;
            err     <= 1'b0;
            running <= 1'b0;
            halted  <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        state   <= S_RUN;
                        upc     <= ADDR_W'(START_ADDR);
                        sp      <= '0;
                        err     <= 1'b0;
                        running <= 1'b1;
                        halted  <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (!stall) begin
                        unique case (op)
                            OP_NEXT: upc <= upc_inc;
                            OP_JUMP: upc <= target;
                            OP_BR_T: upc <= taken ? target : upc_inc;
                            OP_BR_F: upc <= taken ? upc_inc : target;
                            OP_CALL: begin
                                if (full) begin
                                    err     <= 1'b1;
                                    state   <= S_HALT;
                                    running <= 1'b0;
                                    halted  <= 1'b1;
                                end else begin
                                    sp  <= sp + SP_W'(1);
                                    upc <= target;
                                end
                            end
                            OP_RET: begin
                                if (empty) begin
                                    err     <= 1'b1;
                                    state   <= S_HALT;
                                    running <= 1'b0;
                                    halted  <= 1'b1;
                                end else begin
                                    sp  <= sp - SP_W'(1);
                                    upc <= top;
                                end
                            end
                            OP_DISP: upc <= target + ADDR_W'(opcode);
                            OP_HALT: begin
                                state   <= S_HALT;
                                running <= 1'b0;
                                halted  <= 1'b1;
                            end
                            default: upc <= upc;
                        endcase
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    running <= 1'b0;
                    halted  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_micro_sequencer.sv
// tb_micro_sequencer: directed and random checks of micro_sequencer
// against a queue-based behavioural model driving a ROM array.
module tb_micro_sequencer;

    localparam int AW    = 8;
    localparam int DEPTH = 4;
    localparam int START = 0;
    localparam int ASZ   = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          stall = 1'b0;
    logic [3:0]    opcode = '0;
    logic [7:0]    cond = '0;
    logic [15:0]   word;
    logic [AW-1:0] addr;
    logic          running;
    logic          halted;
    logic          err;

    logic [15:0] rom [ASZ];

    int tests = 0;
    int fails = 0;

    int m_st;
    int m_pc;
    int stk[$];
    bit m_err;

    always #5 clk = ~clk;

    assign word = rom[addr];

    micro_sequencer #(
        .ADDR_W(AW),
        .STACK_DEPTH(DEPTH),
        .START_ADDR(START)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .stall(stall),
        .opcode(opcode),
        .cond(cond),
        .word(word),
        .addr(addr),
        .running(running),
        .halted(halted),
        .err(err)
    );

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void model_next();
        logic [15:0] w;
        int op;
        int tgt;
        bit c;
        if (!rst_n) begin
            m_st = 0; m_pc = 0; stk.delete(); m_err = 0;
            return;
        end
        if (m_st != 1) begin
            if (start) begin
                m_st = 1; m_pc = START; stk.delete(); m_err = 0;
            end
            return;
        end
        if (stall) return;
        w   = rom[m_pc];
        op  = int'(w[15:13]);
        tgt = int'(w[AW-1:0]);
        c   = cond[w[12:10]];
        case (op)
            0: m_pc = (m_pc + 1) % ASZ;
            1: m_pc = tgt;
            2: m_pc = c ? tgt : (m_pc + 1) % ASZ;
            3: m_pc = c ? (m_pc + 1) % ASZ : tgt;
            4: begin
                if (stk.size() == DEPTH) begin
                    m_err = 1; m_st = 2;
                end else begin
                    stk.push_back((m_pc + 1) % ASZ);
                    m_pc = tgt;
                end
            end
            5: begin
                if (stk.size() == 0) begin
                    m_err = 1; m_st = 2;
                end else begin
                    m_pc = stk.pop_back();
                end
            end
            6: m_pc = (tgt + int'(opcode)) % ASZ;
            default: m_st = 2;
        endcase
    endfunction

    task automatic tick();
        model_next();
        @(posedge clk);
        #1;
        chk("addr", 32'(addr), 32'(m_pc));
        chk("running", 32'(running), 32'(m_st == 1));
        chk("halted", 32'(halted), 32'(m_st == 2));
        chk("err", 32'(err), 32'(m_err));
    endtask

    task automatic clear_rom();
        for (int i = 0; i < ASZ; i++) rom[i] = 16'h0000;
    endtask

    task automatic restart();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        logic [2:0] opmap [16];
        logic [2:0] o;

        clear_rom();
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_addr", 32'(addr), 32'h0);
        chk("rst_run", 32'(running), 32'h0);
        chk("rst_halt", 32'(halted), 32'h0);
        rst_n = 1'b1;
        tick();

        // straight-line program ending in HALT
        rom[3] = 16'hE000;
        restart();
        chk("seq0", 32'(addr), 32'h0);
        tick(); tick(); tick();
        chk("seq3", 32'(addr), 32'h3);
        tick();
        chk("halt_addr", 32'(addr), 32'h3);
        chk("halt_flag", 32'(halted), 32'h1);
        chk("halt_run", 32'(running), 32'h0);

        // JUMP chain and wrap from 0xFF
        clear_rom();
        rom[8'h00] = 16'h2010;
        rom[8'h10] = 16'h2050;
        rom[8'h50] = 16'h20FF;
        rom[8'hFF] = 16'h0000;
        restart();
        tick(); tick();
        chk("jump", 32'(addr), 32'h50);
        tick();
        chk("jff", 32'(addr), 32'hFF);
        tick();
        chk("wrap", 32'(addr), 32'h00);
        rom[8'h00] = 16'hE000;
        tick();

        // BR_T / BR_F on cond[2]
        clear_rom();
        rom[8'h30] = 16'hE000;
        rom[8'h01] = 16'hE000;
        rom[8'h00] = 16'h4830;
        cond = 8'h04; restart(); tick();
        chk("brt_taken", 32'(addr), 32'h30);
        tick();
        cond = 8'h00; restart(); tick();
        chk("brt_fall", 32'(addr), 32'h01);
        tick();
        rom[8'h00] = 16'h6830;
        cond = 8'h04; restart(); tick();
        chk("brf_fall", 32'(addr), 32'h01);
        tick();
        cond = 8'h00; restart(); tick();
        chk("brf_taken", 32'(addr), 32'h30);
        tick();

        // CALL / RET round trip
        clear_rom();
        rom[8'h00] = 16'h2005;
        rom[8'h05] = 16'h8040;
        rom[8'h40] = 16'hA000;
        rom[8'h06] = 16'hE000;
        restart(); tick(); tick();
        chk("call", 32'(addr), 32'h40);
        tick();
        chk("ret", 32'(addr), 32'h06);
        tick();

        // five nested calls overflow a four-deep stack
        clear_rom();
        rom[8'h00] = 16'h8010;
        rom[8'h10] = 16'h8020;
        rom[8'h20] = 16'h8030;
        rom[8'h30] = 16'h8040;
        rom[8'h40] = 16'h8050;
        restart();
        repeat (5) tick();
        chk("ovf_err", 32'(err), 32'h1);
        chk("ovf_halt", 32'(halted), 32'h1);
        chk("ovf_addr", 32'(addr), 32'h40);

        // RET on empty stack; start clears err
        rom[8'h00] = 16'hA000;
        restart();
        chk("start_clr", 32'(err), 32'h0);
        tick();
        chk("unf_err", 32'(err), 32'h1);
        restart();
        chk("rst_err_clr", 32'(err), 32'h0);
        chk("start_addr", 32'(addr), 32'(START));
        tick();

        // DISPATCH wraps modulo 2^AW
        clear_rom();
        rom[8'h00] = 16'hC0F8;
        rom[8'h02] = 16'hE000;
        opcode = 4'hA;
        restart(); tick();
        chk("dispatch", 32'(addr), 32'h02);
        tick();

        // stall holds everything mid-subroutine
        clear_rom();
        rom[8'h00] = 16'h8010;
        rom[8'h11] = 16'hA000;
        rom[8'h01] = 16'hE000;
        restart(); tick();
        stall = 1'b1;
        repeat (3) begin
            tick();
            chk("stall", 32'(addr), 32'h10);
        end
        stall = 1'b0;
        tick(); tick();
        chk("resume", 32'(addr), 32'h01);
        tick();

        // reset mid-run with a non-empty stack
        rom[8'h11] = 16'h2011;
        restart(); tick(); tick(); tick();
        rst_n = 1'b0;
        tick();
        chk("mid_rst", 32'(addr), 32'h0);
        chk("mid_rst_run", 32'(running), 32'h0);
        rst_n = 1'b1;
        rom[8'h11] = 16'hA000;
        rom[8'h01] = 16'hA000;
        restart(); repeat (4) tick();
        chk("sp_cleared", 32'(err), 32'h1);

        // random programs, inputs and occasional resets
        opmap = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd3,
                  3'd4, 3'd4, 3'd5, 3'd5, 3'd6, 3'd6, 3'd7, 3'd0};
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < ASZ; i++) begin
                o = opmap[$urandom_range(0, 15)];
                rom[i] = {o, 13'($urandom)};
            end
            for (int n = 0; n < 600; n++) begin
                stall  = ($urandom_range(0, 3) == 0);
                start  = ($urandom_range(0, 7) == 0);
                rst_n  = ($urandom_range(0, 199) != 0);
                cond   = 8'($urandom);
                opcode = 4'($urandom);
                tick();
            end
        end
        rst_n = 1'b1;
        start = 1'b0;
        stall = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
